pulse_stretch_out: RTL and testbench
====================================

// Module: pulse_stretch_out
// PURPOSE
//  Output-side counterpart to the button debouncer/one-shot: converts single-cycle CPU/MMIO strobes
//  into clean, minimum-width, minimum-spaced pulses suitable for LEDs, buzzers or off-board logic.
//  Sits between the OTTER MMIO write decode and a Basys3 output pin. Guarantees every accepted
//  strobe yields exactly one ON_CLKS-wide high pulse followed by at least GAP_CLKS low.
// PARAMETERS
//  ON_CLKS   25  output high time in CLK cycles (>=1)
//  GAP_CLKS  50  minimum low time after each pulse in CLK cycles (>=1)
//  Q_W       4   width of pending-strobe counter (queue build only); saturates at 2**Q_W-1
// PORTS
//  CLK      in   1    system clock, all logic on rising edge
//  RST      in   1    synchronous, active-high reset
//  PULSE    in   1    single-cycle request strobe, sampled every edge
//  CLR_OVR  in   1    clears OVERRUN (RST and CLR_OVR both clear; CLR_OVR loses to a same-cycle set)
//  OUT      out  1    stretched output pulse
//  BUSY     out  1    high whenever state != ST_IDLE
//  OVERRUN  out  1    sticky: a strobe was lost
//  PENDING  out  Q_W  strobes accepted but not yet emitted (tied 0 when queue compiled out)
// BEHAVIOUR
//  - Reset: state ST_IDLE, cnt=0, pending=0; OUT=0, BUSY=0, OVERRUN=0, PENDING=0 on next edge. Reset
//    mid-pulse aborts immediately; queued strobes discarded.
//  - Outputs decoded from registered state only; no combinational path from any input to outputs.
//  - States: ST_IDLE -> ST_ON -> ST_GAP -> (ST_ON | ST_IDLE). cnt clears on every state entry.
//  - ST_IDLE: PULSE=1 (or PENDING!=0) -> ST_ON next cycle. Latency: PULSE in cycle n -> OUT=1 in n+1.
//  - ST_ON: OUT=1; exit to ST_GAP when cnt==ON_CLKS-1 (exactly ON_CLKS high cycles).
//  - ST_GAP: OUT=0; on cnt==GAP_CLKS-1: if PULSE or PENDING!=0 -> ST_ON directly (back-to-back
//    period = ON_CLKS+GAP_CLKS), else -> ST_IDLE.
//  - Strobe accept rule: PULSE that starts a pulse (IDLE, or last GAP cycle) is consumed directly,
//    never counted. Any other PULSE while BUSY goes to the queue (or is dropped, see CONFIGURATION).
//  - Pending update: +1 for queued PULSE, -1 when a pulse starts from the queue; both in one cycle
//    -> unchanged. Increment at 2**Q_W-1 is dropped and sets OVERRUN.
//  - cnt width = $clog2(max(ON_CLKS,GAP_CLKS)); never wraps (always cleared on exit).
// CONFIGURATION
//  - Macro PULSE_STRETCH_QUEUE_EN defined: pending counter present, behaviour as above.
//  - Undefined: no counter; PENDING=0; PULSE while BUSY (except last GAP cycle) is dropped and
//    sets OVERRUN. FSM and timing otherwise identical.
// STRUCTURE
//  - Package pulse_stretch_pkg: typedef enum ps_state_t {ST_IDLE, ST_ON, ST_GAP}; shared
//    localparam defaults for ON_CLKS/GAP_CLKS so MMIO wrapper and TB agree.
//  - Sub-module pulse_pending_ctr (Q_W-wide saturating up/down counter with inc, dec, sat out),
//    instantiated only under PULSE_STRETCH_QUEUE_EN.
//  - Top: state register, cnt, next-state always_comb with defaults, OVERRUN flop.
// TESTING (ON_CLKS=3, GAP_CLKS=2, Q_W=2 unless noted; cycle = CLK edge index)
//  1. RST cycles 0-2, PULSE @10 -> OUT=1 @11-13, OUT=0 @14+, BUSY=1 @11-15, BUSY=0 @16.
//  2. QUEUE_EN, PULSE @10 and @12 -> OUT=1 @11-13 and @16-18; PENDING=1 @13-15, 0 @16.
//  3. QUEUE_EN, PULSE @11,12,13 then @14,15 (last GAP cycle) -> PENDING=3, OVERRUN=1 after the
//     4th queued strobe; PULSE@15 starts pulse directly, PENDING stays 3; CLR_OVR -> OVERRUN=0.
//  4. Queue off, PULSE @10 and @12 -> single pulse @11-13, OVERRUN=1 @13; PULSE @15 -> OUT=1 @16.
//  5. PULSE @10, RST @12 -> OUT=0 @13, BUSY=0, PENDING=0, OVERRUN=0; PULSE @20 -> OUT=1 @21.
//  6. Defaults (25/50): continuous PULSE every cycle for 300 cycles -> OUT period exactly 75,
//     high 25; never high for <25 or low for <50 between pulses.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// Shared types and defaults for the output pulse stretcher.
// Defaults are kept here so the MMIO wrapper and the bench agree.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } ps_state_t;

    localparam int PS_ON_CLKS  = 25;
    localparam int PS_GAP_CLKS = 50;
    localparam int PS_Q_W      = 4;

    // Counter width large enough for the longer phase; never below 1 bit.
    function automatic int ps_cnt_w(input int on_clks, input int gap_clks);
        int m;
        m = (on_clks > gap_clks) ? on_clks : gap_clks;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pulse_stretch_out_ctr.sv
// Saturating up/down counter of strobes waiting for a pulse slot.
// Used by pulse_stretch_out only when PULSE_STRETCH_QUEUE_EN is defined.
module pulse_pending_ctr
    import pulse_stretch_pkg::*;
#(
    parameter int W = PS_Q_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         INC,
    input  logic         DEC,
    output logic [W-1:0] COUNT,
    output logic         SAT
);

    assign SAT = &COUNT;

    always_ff @(posedge CLK) begin
        if (RST) begin
            COUNT <= '0;
        end else begin
            unique case ({INC, DEC})
                2'b10: if (!SAT) COUNT <= COUNT + 1'b1;
                2'b01: if (COUNT != '0) COUNT <= COUNT - 1'b1;
                default: COUNT <= COUNT;
            endcase
        end
    end

endmodule

// File: rtl/pulse_stretch_out.sv
// Strobe to fixed-width, minimum-spaced output pulse converter.
// Define PULSE_STRETCH_QUEUE_EN to queue strobes that arrive while busy.
module pulse_stretch_out
    import pulse_stretch_pkg::*;
#(
    parameter int ON_CLKS  = PS_ON_CLKS,
    parameter int GAP_CLKS = PS_GAP_CLKS,
    parameter int Q_W      = PS_Q_W
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           PULSE,
    input  logic           CLR_OVR,
    output logic           OUT,
    output logic           BUSY,
    output logic           OVERRUN,
    output logic [Q_W-1:0] PENDING
);

    localparam int CW = ps_cnt_w(ON_CLKS, GAP_CLKS);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CLKS - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CLKS - 1);

    ps_state_t     state;
    ps_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic on_done;
    logic gap_done;
    logic start_ok;
    logic start;
    logic have_pend;
    logic take_q;
    logic queue_req;
    logic ovr_set;

    assign on_done  = (state == ST_ON)  && (cnt == ON_LAST);
    assign gap_done = (state == ST_GAP) && (cnt == GAP_LAST);

    // A strobe landing in a start slot is used directly and never queued.
    assign start_ok  = (state == ST_IDLE) || gap_done;
    assign start     = start_ok && (PULSE || have_pend);
    assign take_q    = start && !PULSE;
    assign queue_req = PULSE && !start_ok;

`ifdef PULSE_STRETCH_QUEUE_EN
    logic [Q_W-1:0] pend_cnt;
    logic           pend_sat;

    pulse_pending_ctr #(
        .W (Q_W)
    ) u_pend (
        .CLK   (CLK),
        .RST   (RST),
        .INC   (queue_req && !pend_sat),
        .DEC   (take_q),
        .COUNT (pend_cnt),
        .SAT   (pend_sat)
    );

    assign have_pend = |pend_cnt;
    assign ovr_set   = queue_req && pend_sat;
    assign PENDING   = pend_cnt;
`else
    assign have_pend = 1'b0;
    assign ovr_set   = queue_req;
    assign PENDING   = '0;

    logic unused_take_q;
    assign unused_take_q = take_q;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        unique case (1'b1)
            (state == ST_IDLE): begin
                cnt_nxt = '0;
                if (start) state_nxt = ST_ON;
            end
            (state == ST_ON): begin
                if (on_done) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                end
            end
            (state == ST_GAP): begin
                if (gap_done) begin
                    state_nxt = start ? ST_ON : ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A same-cycle loss wins over the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERRUN <= 1'b0;
        end else if (ovr_set) begin
            OVERRUN <= 1'b1;
        end else if (CLR_OVR) begin
            OVERRUN <= 1'b0;
        end
    end

    assign OUT  = (state == ST_ON);
    assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_pulse_stretch_out.sv
// Bench for pulse_stretch_out: small-parameter DUT checked against a phase model,
// plus a default-parameter DUT checked for pulse width and spacing.
module tb_pulse_stretch_out;

    localparam int ON  = 3;
    localparam int GAP = 2;
    localparam int QW  = 2;
    localparam int QMAX = (1 << QW) - 1;
`ifdef PULSE_STRETCH_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic PULSE = 1'b0;
    logic CLR_OVR = 1'b0;

    logic          out_s, busy_s, ovr_s;
    logic [QW-1:0] pend_s;
    logic          out_d, busy_d, ovr_d;
    logic [3:0]    pend_d;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pulse_stretch_out #(
        .ON_CLKS  (ON),
        .GAP_CLKS (GAP),
        .Q_W      (QW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .PULSE   (PULSE),
        .CLR_OVR (CLR_OVR),
        .OUT     (out_s),
        .BUSY    (busy_s),
        .OVERRUN (ovr_s),
        .PENDING (pend_s)
    );

    pulse_stretch_out dut_def (
        .CLK     (CLK),
        .RST     (RST),
        .PULSE   (PULSE),
        .CLR_OVR (CLR_OVR),
        .OUT     (out_d),
        .BUSY    (busy_d),
        .OVERRUN (ovr_d),
        .PENDING (pend_d)
    );

    // Model: age = cycles since current pulse began, -1 when idle.
    int m_age = -1;
    int m_pend = 0;
    bit m_ovr = 1'b0;
    bit chk_en = 1'b0;

    always @(posedge CLK) begin
        bit can_start;
        bit set;
        if (RST) begin
            m_age  = -1;
            m_pend = 0;
            m_ovr  = 1'b0;
            chk_en = 1'b1;
        end else begin
            can_start = (m_age < 0) || (m_age == ON + GAP - 1);
            set = 1'b0;
            if (can_start) begin
                if (PULSE) m_age = 0;
                else if (m_pend > 0) begin
                    m_pend--;
                    m_age = 0;
                end else m_age = -1;
            end else begin
                m_age++;
                if (PULSE) begin
                    if (QEN && m_pend < QMAX) m_pend++;
                    else set = 1'b1;
                end
            end
            if (set) m_ovr = 1'b1;
            else if (CLR_OVR) m_ovr = 1'b0;
        end
        #1;
        if (chk_en) begin
            logic e_out, e_busy;
            e_out  = (m_age >= 0) && (m_age < ON);
            e_busy = (m_age >= 0);
            checks++;
            if (out_s !== e_out || busy_s !== e_busy ||
                ovr_s !== m_ovr || pend_s !== QW'(m_pend)) begin
                failures++;
                $display("FAIL model t=%0t out=%b/%b busy=%b/%b ovr=%b/%b pend=%0d/%0d (got/exp)",
                         $time, out_s, e_out, busy_s, e_busy, ovr_s, m_ovr,
                         pend_s, m_pend);
            end
        end
    end

    task automatic pin(input int t, input int k, input string nm,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL t%0d k%0d %s got=%0d exp=%0d", t, k, nm, act, exp);
        end
    endtask

    function automatic bit stim_pulse(input int t, input int k);
        unique case (t)
            1: return k == 10;
            2: return k == 10 || k == 12;
            3: return (k >= 10 && k <= 15) || k == 17;
            4: return k == 10 || k == 12 || k == 15;
            5: return k == 10 || k == 20;
            6: return k >= 3 && k <= 302;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit stim_rst(input int t, input int k);
        return (k <= 2) || (t == 5 && k == 12);
    endfunction

    function automatic bit stim_clr(input int t, input int k);
        return t == 3 && (k == 17 || k == 20);
    endfunction

    task automatic hand_pins(input int t, input int k);
        int o, b, v, p;
        o = int'(out_s);
        b = int'(busy_s);
        v = int'(ovr_s);
        p = int'(pend_s);
        if (t == 1) begin
            if (k == 5) begin
                pin(t, k, "rst_out", o, 0);
                pin(t, k, "rst_busy", b, 0);
                pin(t, k, "rst_ovr", v, 0);
                pin(t, k, "rst_pend", p, 0);
            end
            if (k == 11 || k == 13) pin(t, k, "out_hi", o, 1);
            if (k == 14) pin(t, k, "out_lo", o, 0);
            if (k == 15) pin(t, k, "busy_gap", b, 1);
            if (k == 16) pin(t, k, "busy_idle", b, 0);
        end
        if (t == 2) begin
            if (k == 11) pin(t, k, "out_first", o, 1);
            if (QEN) begin
                if (k == 13 || k == 15) pin(t, k, "pend_one", p, 1);
                if (k == 16) pin(t, k, "pend_drain", p, 0);
                if (k == 16 || k == 18) pin(t, k, "out_second", o, 1);
                if (k == 19) pin(t, k, "out_lo", o, 0);
            end else begin
                if (k == 13) pin(t, k, "ovr_drop", v, 1);
                if (k == 16) pin(t, k, "out_idle", o, 0);
            end
        end
        if (t == 3) begin
            if (QEN) begin
                if (k == 12) pin(t, k, "pend_1", p, 1);
                if (k == 14) pin(t, k, "pend_3", p, 3);
                if (k == 14) pin(t, k, "ovr_not_yet", v, 0);
                if (k == 15) pin(t, k, "ovr_sat", v, 1);
                if (k == 16) pin(t, k, "pend_kept", p, 3);
            end else begin
                if (k == 12) pin(t, k, "ovr_drop", v, 1);
                if (k == 16) pin(t, k, "pend_zero", p, 0);
            end
            if (k == 16) pin(t, k, "out_direct", o, 1);
            if (k == 18) pin(t, k, "ovr_clr_loses", v, 1);
            if (k == 21) pin(t, k, "ovr_cleared", v, 0);
        end
        if (t == 4) begin
            if (k == 14) pin(t, k, "out_lo", o, 0);
            if (k == 16) pin(t, k, "out_direct", o, 1);
            if (QEN) begin
                if (k == 16) pin(t, k, "pend_kept", p, 1);
                if (k == 21) pin(t, k, "out_from_q", o, 1);
                if (k == 21) pin(t, k, "pend_drain", p, 0);
            end else begin
                if (k == 13) pin(t, k, "ovr_drop", v, 1);
            end
        end
        if (t == 5) begin
            if (k == 12) pin(t, k, "out_pre_rst", o, 1);
            if (k == 13) begin
                pin(t, k, "abort_out", o, 0);
                pin(t, k, "abort_busy", b, 0);
                pin(t, k, "abort_pend", p, 0);
                pin(t, k, "abort_ovr", v, 0);
            end
            if (k == 21) pin(t, k, "out_restart", o, 1);
        end
    endtask

    logic prev_d;
    int   run_d;
    int   nrise;

    task automatic run_test(input int t, input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge CLK);
            hand_pins(t, k);
            if (t == 6 && k >= 3 && k <= 310) begin
                if (out_d !== prev_d) begin
                    if (prev_d === 1'b1) pin(t, k, "t6_high_len", run_d, 25);
                    else if (nrise > 0) pin(t, k, "t6_low_len", run_d, 50);
                    if (out_d === 1'b1) begin
                        if (nrise < 4) pin(t, k, "t6_rise_at", k, 4 + 75 * nrise);
                        nrise++;
                    end
                    run_d = 1;
                end else begin
                    run_d++;
                end
                prev_d = out_d;
            end
            RST     = stim_rst(t, k);
            PULSE   = stim_pulse(t, k);
            CLR_OVR = stim_clr(t, k);
        end
    endtask

    initial begin
        run_test(1, 24);
        run_test(2, 26);
        run_test(3, 30);
        run_test(4, 26);
        run_test(5, 26);
        prev_d = 1'b0;
        run_d  = 0;
        nrise  = 0;
        run_test(6, 320);
        pin(6, 320, "t6_rise_count", (nrise >= 4) ? 1 : 0, 1);
        @(negedge CLK);
        PULSE = 1'b0;
        RST   = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
